// File: rtl/key_cond_pkg.sv
// key_cond_pkg
// Shared definitions for the key conditioner: per-channel edge-mode encodings
// and the helper that decides whether a debounced transition is an event.
package key_cond_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;  // press
  localparam logic [1:0] EDGE_FALL = 2'b10;  // release
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  function automatic logic edge_qualifies(input logic [1:0] mode,
                                          input logic       rise,
                                          input logic       fall);
    return (rise && ((mode & EDGE_RISE) != EDGE_NONE)) ||
           (fall && ((mode & EDGE_FALL) != EDGE_NONE));
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// key_conditioner_if
// Groups the pin-side inputs, runtime controls and conditioned outputs of the
// key conditioner.
//   data_in   raw asynchronous pin levels
//   edge_mode per channel [2i+1:2i]: none / rise / fall / both
//   evt_clr   per-channel single-cycle clear of evt_flags
//   level_out debounced, normalised level (1 = active)
//   pulse_out extended pulse on a qualifying edge
//   hold_out  long-press indication
//   evt_flags sticky qualifying-edge flags
//   irq       registered OR of evt_flags
// master: the side driving pins/controls; slave: the conditioner itself.
interface key_conditioner_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0]   data_in;
  logic [2*WIDTH-1:0] edge_mode;
  logic [WIDTH-1:0]   evt_clr;
  logic [WIDTH-1:0]   level_out;
  logic [WIDTH-1:0]   pulse_out;
  logic [WIDTH-1:0]   hold_out;
  logic [WIDTH-1:0]   evt_flags;
  logic               irq;

  modport master (
    output data_in, edge_mode, evt_clr,
    input  level_out, pulse_out, hold_out, evt_flags, irq
  );

  modport slave (
    input  data_in, edge_mode, evt_clr,
    output level_out, pulse_out, hold_out, evt_flags, irq
  );
endinterface

// File: rtl/key_cond_channel.sv
// key_cond_channel
// One input channel: 2-flop synchroniser, polarity normalisation, debounce,
// edge qualification, extended pulse, long-press detection and sticky flag.
//   clk, rst  fabric clock, asynchronous active-high reset
//   pin       raw asynchronous pin level
//   mode      edge selection (key_cond_pkg EDGE_*)
//   clr       single-cycle clear of flag
//   level     debounced active level
//   pulse     PULSE_EXT-cycle pulse following a qualifying edge
//   hold      active level has lasted HOLD_CYCLES cycles
//   flag      sticky qualifying-edge flag
module key_cond_channel
  import key_cond_pkg::*;
#(
  parameter string POLARITY      = "LOW",
  parameter int    TIMEOUT       = 50000,
  parameter int    TIMEOUT_WIDTH = 16,
  parameter int    PULSE_EXT     = 1,
  parameter bit    RETRIGGER     = 1'b0,
  parameter int    HOLD_CYCLES   = 50000000,
  parameter int    HOLD_WIDTH    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       pulse,
  output logic       hold,
  output logic       flag
);

  localparam bit ACT_HIGH = (POLARITY == "HIGH");
  // Synchroniser resets to the idle pin level so reset release is not a press.
  localparam logic IDLE_PIN = ACT_HIGH ? 1'b0 : 1'b1;
  localparam int PW = $clog2(PULSE_EXT + 1);

  logic                     sync1, sync2;
  logic                     act;
  logic                     db, db_d;
  logic [TIMEOUT_WIDTH-1:0] db_cnt;
  logic [PW-1:0]            pulse_cnt;
  logic [HOLD_WIDTH-1:0]    hold_cnt;
  logic                     rise, fall, qual;

  assign act  = ACT_HIGH ? sync2 : ~sync2;
  assign rise = db & ~db_d;
  assign fall = ~db & db_d;
  assign qual = edge_qualifies(mode, rise, fall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= IDLE_PIN;
      sync2     <= IDLE_PIN;
      db        <= 1'b0;
      db_d      <= 1'b0;
      db_cnt    <= '0;
      pulse_cnt <= '0;
      hold_cnt  <= '0;
      flag      <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;

      // Any cycle where act agrees with db restarts the stability count.
      if (act == db) begin
        db_cnt <= '0;
      end else if (db_cnt == TIMEOUT_WIDTH'(TIMEOUT - 1)) begin
        db     <= act;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      db_d <= db;

      if (qual && (RETRIGGER || pulse_cnt == '0)) begin
        pulse_cnt <= PW'(PULSE_EXT);
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - 1'b1;
      end

      if (!db) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_WIDTH'(HOLD_CYCLES)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end

      // A new event in the same cycle as a clear must not be lost.
      if (qual) begin
        flag <= 1'b1;
      end else if (clr) begin
        flag <= 1'b0;
      end
    end
  end

  assign level = db;
  assign pulse = (pulse_cnt != '0);
  assign hold  = (hold_cnt == HOLD_WIDTH'(HOLD_CYCLES));

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner
// Multi-channel push-button / GPIO conditioner. Each channel is an
// independent key_cond_channel; the combined interrupt is a registered OR of
// all sticky event flags.
//   clk  fabric clock
//   rst  asynchronous active-high reset
//   bus  key_conditioner_if.slave (pins, controls and conditioned outputs)
module key_conditioner #(
  parameter int    WIDTH         = 2,
  parameter string POLARITY      = "LOW",
  parameter int    TIMEOUT       = 50000,
  parameter int    TIMEOUT_WIDTH = 16,
  parameter int    PULSE_EXT     = 1,
  parameter bit    RETRIGGER     = 1'b0,
  parameter int    HOLD_CYCLES   = 50000000,
  parameter int    HOLD_WIDTH    = 26
) (
  input logic               clk,
  input logic               rst,
  key_conditioner_if.slave  bus
);

  logic [WIDTH-1:0] level_w;
  logic [WIDTH-1:0] pulse_w;
  logic [WIDTH-1:0] hold_w;
  logic [WIDTH-1:0] flag_w;
  logic             irq_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    key_cond_channel #(
      .POLARITY      (POLARITY),
      .TIMEOUT       (TIMEOUT),
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
      .PULSE_EXT     (PULSE_EXT),
      .RETRIGGER     (RETRIGGER),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .HOLD_WIDTH    (HOLD_WIDTH)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .pin   (bus.data_in[i]),
      .mode  (bus.edge_mode[2*i +: 2]),
      .clr   (bus.evt_clr[i]),
      .level (level_w[i]),
      .pulse (pulse_w[i]),
      .hold  (hold_w[i]),
      .flag  (flag_w[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |flag_w;
    end
  end

  assign bus.level_out = level_w;
  assign bus.pulse_out = pulse_w;
  assign bus.hold_out  = hold_w;
  assign bus.evt_flags = flag_w;
  assign bus.irq       = irq_q;

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
Parametrised multi-channel input conditioner replacing the separate debounce plus per-key edge-detector chain used on board push-buttons and GPIO inputs. Per channel: 2-flop synchroniser, polarity normalisation, debounce, runtime-selectable edge detection, extended pulse output, long-press detection and sticky event flags with a combined interrupt. Sits between raw pins (KEY, GPIO) and the soc_system port inputs, clocked from the 50 MHz fabric clock.

Parameters:
WIDTH, 2, number of channels.
POLARITY, "LOW", "LOW" means active-low (pressed = 0), "HIGH" means active-high; applies to all channels.
TIMEOUT, 50000, consecutive stable cycles required to accept a level change (1 ms at 50 MHz).
TIMEOUT_WIDTH, 16, debounce counter width; must satisfy 2**TIMEOUT_WIDTH > TIMEOUT.
PULSE_EXT, 1, pulse_out length in cycles (>=1).
RETRIGGER, 0, 1 = a new qualifying edge during an active pulse reloads the pulse counter; 0 = ignored.
HOLD_CYCLES, 50000000, cycles of continuous active level before hold_out asserts (1 s).
HOLD_WIDTH, 26, hold counter width; must satisfy 2**HOLD_WIDTH > HOLD_CYCLES.

Ports:
clk  input  1  fabric clock.
rst  input  1  asynchronous, active-high reset.
data_in  input  WIDTH  raw asynchronous pin levels.
edge_mode  input  2*WIDTH  per channel [2i+1:2i]: 00 none, 01 rising (press), 10 falling (release), 11 both.
evt_clr  input  WIDTH  per-channel single-cycle clear of evt_flags.
level_out  output  WIDTH  debounced, normalised level (1 = active).
pulse_out  output  WIDTH  extended pulse on a qualifying edge.
hold_out  output  WIDTH  high while a press has lasted >= HOLD_CYCLES; low on release.
evt_flags  output  WIDTH  sticky qualifying-edge flags.
irq  output  1  registered OR of evt_flags.

Behaviour:
- Reset: every output 0; synchroniser flops load the inactive pin level (1 for "LOW", 0 for "HIGH"). All counters are cleared. No edge is generated on release of reset.
- Sync: 2 flops per channel. act = normalised stage-2 output.
- Debounce: counter db_cnt and state db (drives level_out).
  - If act == db: db_cnt <= 0.
  - Otherwise db_cnt increments. When db_cnt == TIMEOUT-1 and act != db still holds: db <= act and db_cnt <= 0.
  - A glitch shorter than TIMEOUT cycles is fully rejected.
  - Pin-to-level_out latency: 2 + TIMEOUT cycles.
- Edge: rise/fall derived from db versus its 1-cycle-delayed copy. Qualifying = (rise & mode[0]) | (fall & mode[1]). edge_mode is sampled on the cycle the edge is detected.
- Pulse: pulse_out asserts the cycle after the qualifying edge and stays high exactly PULSE_EXT cycles (counter).
  - RETRIGGER=1: an edge during the pulse reloads the counter to PULSE_EXT.
  - RETRIGGER=0: an edge during the pulse is ignored.
- Hold: hold counter runs while db = 1 and saturates at HOLD_CYCLES. hold_out = 1 once the count reaches HOLD_CYCLES, and clears the cycle after db falls. hold_out is independent of edge_mode.
- Flags: evt_flags[i] sets on a qualifying edge (same cycle pulse_out rises) and clears when evt_clr[i] = 1. If set and clear occur in the same cycle, set wins. irq is registered one cycle after evt_flags.
- Channels are fully independent; simultaneous events on several channels are all captured.
- Reset asserted mid-operation returns every channel to its reset state immediately (asynchronous).

Decomposition:
- Shared package key_cond_pkg: edge-mode constants EDGE_NONE=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11.
- One sub-module, key_cond_channel, holds a single channel's sync, debounce, edge, pulse, hold and flag logic.
- key_conditioner generates WIDTH instances of key_cond_channel and builds irq.

Test Plan:
Bench parameters: WIDTH=2, POLARITY="LOW", TIMEOUT=8, PULSE_EXT=3, HOLD_CYCLES=20, RETRIGGER=0.
- Reset release with data_in=2'b11 -> all outputs 0 for 50 cycles; no pulse.
- Ch0 mode 01: drive data_in[0]=0 and hold -> level_out[0]=1 at cycle 10; pulse_out[0]=1 for cycles 11-13; evt_flags[0]=1 at 11; irq=1 at 12.
- Ch0 low for 5 cycles, then high -> level_out, pulse_out and evt_flags stay 0 (glitch rejected).
- Ch1 mode 11: press then release after 40 cycles -> two 3-cycle pulses; hold_out[1] rises 20 cycles after level_out[1] and drops the cycle after release.
- evt_clr[0] and a new qualifying edge on ch0 in the same cycle -> evt_flags[0] remains 1. evt_clr[0] alone -> flag 0 next cycle, irq 0 one cycle later.
- RETRIGGER=1 and PULSE_EXT=20 (second bench), ch0 mode 11, press, then release 10 cycles after level_out rises -> pulse_out[0] continuous until 20 cycles after the release edge. Reset asserted mid-pulse -> pulse_out=0 immediately.
